// File: rtl/serial_adder.sv
// serial_adder: multi-cycle WIDTH-bit adder that resolves BITS_PER_CYCLE
// result bits per clock, LSB first, through a single carry register.
// Handshakes: operands over in_valid/in_ready, result over out_valid/out_ready.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub port (a - b mode).
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int STEPS = WIDTH / BPC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ripple-add one BPC-bit slice.
    // Result packing: {carry into slice MSB, carry out of slice, slice sum}.
    // The carry into the slice MSB is only meaningful on the last step, where
    // the slice MSB is operand bit WIDTH-1 and feeds the signed overflow flag.
    function automatic logic [BPC+1:0] add_slice(
        input logic [BPC-1:0] x,
        input logic [BPC-1:0] y,
        input logic           c
    );
        logic [BPC-1:0] s;
        logic           cc;
        logic           c_msb;
        s     = '0;
        cc    = c;
        c_msb = c;
        for (int i = 0; i < BPC; i++) begin
            if (i == BPC - 1) begin
                c_msb = cc;
            end
            s[i] = x[i] ^ y[i] ^ cc;
            cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
        end
        return {c_msb, cc, s};
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] shadow;

    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [BPC-1:0]   slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] shadow_nxt;

    // Handshake flags decode from registered state only.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == LAST_STEP);

    // Operand B and carry-in as seen by the adder; subtraction is a + ~b + 1.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_eff = sub ? ~b : b;
        c_eff = sub ? 1'b1 : cin;
`else
        b_eff = b;
        c_eff = cin;
`endif
    end

    // One step of the serial datapath: add the low slice, shift result in at the top.
    always_comb begin
        {slice_cmsb, slice_cout, slice_sum} = add_slice(opa[BPC-1:0], opb[BPC-1:0], carry);
        shadow_nxt = (shadow >> BPC) | (WIDTH'(slice_sum) << (WIDTH - BPC));
    end

    // Control state, carry, step counter and the registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt   <= '0;
                        carry <= c_eff;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry <= slice_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_step) begin
                        sum      <= shadow_nxt;
                        cout     <= slice_cout;
                        overflow <= slice_cmsb ^ slice_cout;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand shift registers and result shadow; contents are don't-care until accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            opa    <= a;
            opb    <= b_eff;
            shadow <= '0;
        end else if (state == ST_RUN) begin
            opa    <= opa >> BPC;
            opb    <= opb >> BPC;
            shadow <= shadow_nxt;
        end
    end

endmodule
